// File: rtl/frame_streamer.sv
// rtl/frame_streamer.sv - raster transmitter: frame store to pixel stream with blanking and zero tail rows
module frame_streamer #(
    parameter int WIDTH       = 24,
    parameter int HEIGHT      = 32,
    parameter int PIX_W       = 21,
    parameter int ADDR_W      = 10,
    parameter int MEM_LATENCY = 2,
    parameter int HBLANK      = 2,
    parameter int TAIL_ROWS   = 4
) (
    input  logic                    clk_in,
    input  logic                    rst_in,
    input  logic                    start_in,
    output logic                    busy_out,
    output logic                    done_out,
    output logic [ADDR_W-1:0]       mem_addr_out,
    output logic                    mem_rd_en_out,
    input  logic signed [PIX_W-1:0] mem_data_in,
    output logic signed [PIX_W-1:0] pixel_data_out,
    output logic [4:0]              hcount_out,
    output logic [4:0]              vcount_out,
    output logic                    data_valid_out
);

    localparam int RW_RAW = $clog2(HEIGHT + TAIL_ROWS + 1);
    localparam int RW     = (RW_RAW > 5) ? RW_RAW : 5;
    localparam int BW     = $clog2(HBLANK + 1);

    localparam logic [4:0]    H_LAST   = 5'(WIDTH - 1);
    localparam logic [BW-1:0] B_LAST   = BW'(HBLANK - 1);
    localparam logic [RW-1:0] IMG_LAST = RW'(HEIGHT - 1);
    localparam logic [RW-1:0] ROW_LAST = RW'(HEIGHT + TAIL_ROWS - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_ACTIVE,
        S_HBLANK,
        S_TAIL,
        S_DRAIN,
        S_DONE
    } state_t;

    state_t state, state_nxt;

    logic [4:0]        hcnt;
    logic [BW-1:0]     bcnt;
    logic [RW-1:0]     row;
    logic [ADDR_W-1:0] addr;
    logic              row_end;
    logic              blank_end;
    logic              issue_valid;
    logic              issue_tail;

    logic [MEM_LATENCY-1:0] sr_valid;
    logic [MEM_LATENCY-1:0] sr_tail;
    logic [4:0]             sr_h [MEM_LATENCY];
    logic [4:0]             sr_v [MEM_LATENCY];

    assign row_end      = (hcnt == H_LAST);
    assign blank_end    = (bcnt == B_LAST);
    assign mem_addr_out = addr;

    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt     = state;
        busy_out      = 1'b1;
        done_out      = 1'b0;
        mem_rd_en_out = 1'b0;
        issue_valid   = 1'b0;
        issue_tail    = 1'b0;
        case (state)
            S_IDLE: begin
                busy_out = 1'b0;
                if (start_in) state_nxt = S_ACTIVE;
            end
            S_ACTIVE: begin
                mem_rd_en_out = 1'b1;
                issue_valid   = 1'b1;
                if (row_end) state_nxt = S_HBLANK;
            end
            S_TAIL: begin
                issue_valid = 1'b1;
                issue_tail  = 1'b1;
                if (row_end) state_nxt = S_HBLANK;
            end
            S_HBLANK: begin
                if (blank_end) begin
                    if (row == ROW_LAST)      state_nxt = S_DRAIN;
                    else if (row < IMG_LAST)  state_nxt = S_ACTIVE;
                    else                      state_nxt = S_TAIL;
                end
            end
            S_DRAIN: begin
                if (sr_valid == '0) state_nxt = S_DONE;
            end
            S_DONE: begin
                done_out  = 1'b1;
                state_nxt = S_IDLE;
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    // Address advances by one per issued pixel, so row-major order needs no multiplier.
    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            hcnt <= '0;
            bcnt <= '0;
            row  <= '0;
            addr <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (start_in) begin
                        hcnt <= '0;
                        bcnt <= '0;
                        row  <= '0;
                        addr <= '0;
                    end
                end
                S_ACTIVE: begin
                    addr <= addr + ADDR_W'(1);
                    hcnt <= row_end ? 5'd0 : hcnt + 5'd1;
                end
                S_TAIL: begin
                    hcnt <= row_end ? 5'd0 : hcnt + 5'd1;
                end
                S_HBLANK: begin
                    if (blank_end) begin
                        bcnt <= '0;
                        row  <= row + RW'(1);
                    end else begin
                        bcnt <= bcnt + BW'(1);
                    end
                end
                default: ;
            endcase
        end
    end

    // Issue-side tags travel alongside the memory read so they line up with mem_data_in.
    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            sr_valid <= '0;
            sr_tail  <= '0;
            for (int i = 0; i < MEM_LATENCY; i++) begin
                sr_h[i] <= '0;
                sr_v[i] <= '0;
            end
        end else begin
            sr_valid[0] <= issue_valid;
            sr_tail[0]  <= issue_tail;
            sr_h[0]     <= hcnt;
            sr_v[0]     <= row[4:0];
            for (int i = 1; i < MEM_LATENCY; i++) begin
                sr_valid[i] <= sr_valid[i-1];
                sr_tail[i]  <= sr_tail[i-1];
                sr_h[i]     <= sr_h[i-1];
                sr_v[i]     <= sr_v[i-1];
            end
        end
    end

    // Counts hold through blanking so downstream sees the hcount wrap at each new row.
    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            data_valid_out <= 1'b0;
            pixel_data_out <= '0;
            hcount_out     <= '0;
            vcount_out     <= '0;
        end else begin
            data_valid_out <= sr_valid[MEM_LATENCY-1];
            if (sr_valid[MEM_LATENCY-1]) begin
                pixel_data_out <= sr_tail[MEM_LATENCY-1] ? '0 : mem_data_in;
                hcount_out     <= sr_h[MEM_LATENCY-1];
                vcount_out     <= sr_v[MEM_LATENCY-1];
            end else begin
                pixel_data_out <= '0;
            end
        end
    end

endmodule

// File: tb/tb_frame_streamer.sv
// tb/tb_frame_streamer.sv - directed self-checking bench for frame_streamer
module tb_frame_streamer;
    localparam int W  = 24;
    localparam int H  = 32;
    localparam int PW = 21;
    localparam int AW = 10;
    localparam int L  = 2;
    localparam int HB = 2;
    localparam int TR = 4;

    logic                 clk = 1'b0;
    logic                 rst_n = 1'b0;
    logic                 start = 1'b0;
    logic                 busy;
    logic                 done;
    logic [AW-1:0]        addr;
    logic                 rd_en;
    logic signed [PW-1:0] mem_data;
    logic signed [PW-1:0] pixel;
    logic [4:0]           hcount;
    logic [4:0]           vcount;
    logic                 valid;

    logic signed [PW-1:0] mem [1024];
    logic signed [PW-1:0] st1 = '0;
    logic signed [PW-1:0] st2 = '0;

    int n_cmp = 0;
    int n_err = 0;

    frame_streamer #(
        .WIDTH(W), .HEIGHT(H), .PIX_W(PW), .ADDR_W(AW),
        .MEM_LATENCY(L), .HBLANK(HB), .TAIL_ROWS(TR)
    ) dut (
        .clk_in(clk),
        .rst_in(rst_n),
        .start_in(start),
        .busy_out(busy),
        .done_out(done),
        .mem_addr_out(addr),
        .mem_rd_en_out(rd_en),
        .mem_data_in(mem_data),
        .pixel_data_out(pixel),
        .hcount_out(hcount),
        .vcount_out(vcount),
        .data_valid_out(valid)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (rd_en) st1 <= mem[addr];
        st2 <= st1;
    end
    assign mem_data = st2;

    task automatic check_eq(input string tag, input logic signed [63:0] got, input logic signed [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic fill_mem(input int mode);
        for (int i = 0; i < 1024; i++) begin
            if (mode == 0) mem[i] = PW'(i);
            else           mem[i] = (i % 2 == 1) ? 21'sh100000 : 21'sh1FFFFF;
        end
    endtask

    function automatic logic signed [PW-1:0] exp_pix(input int mode, input int n);
        int r;
        int a;
        r = n / W;
        a = r * W + (n % W);
        if (r >= H)    return '0;
        if (mode == 0) return PW'(a);
        return (a % 2 == 1) ? 21'sh100000 : 21'sh1FFFFF;
    endfunction

    task automatic run_frame(input int mode, input bit restart_at_done);
        int nvalid = 0;
        int first = -1;
        int last = -1;
        int done_cyc = -1;
        int ndone = 0;
        int nrd = 0;
        int errs_pix = 0;
        int errs_gap = 0;
        int gap = 0;
        int pix_5_10 = -1;
        int tail_v [TR];
        for (int k = 0; k < TR; k++) tail_v[k] = -1;

        start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        check_eq("busy_c0", busy, 1);
        check_eq("rd_en_c0", rd_en, 1);
        check_eq("addr_c0", addr, 0);
        nrd = nrd + int'(rd_en);

        for (int cyc = 1; cyc <= 945; cyc++) begin
            @(posedge clk);
            @(negedge clk);
            if (cyc == 100) start = 1'b1;
            if (cyc == 101) start = 1'b0;
            nrd = nrd + int'(rd_en);
            if (done) begin
                ndone++;
                done_cyc = cyc;
            end
            if (valid) begin
                if (first < 0) first = cyc;
                if (nvalid > 0 && nvalid % W == 0 && gap != HB) errs_gap++;
                if (nvalid % W != 0 && gap != 0) errs_gap++;
                gap = 0;
                if (hcount != 5'(nvalid % W))         errs_pix++;
                if (vcount != 5'((nvalid / W) % 32))  errs_pix++;
                if (pixel !== exp_pix(mode, nvalid))  errs_pix++;
                if (hcount == 5 && vcount == 10 && nvalid < H * W) pix_5_10 = int'(pixel);
                if (nvalid >= H * W && hcount == 0 && nvalid < (H + TR) * W)
                    tail_v[(nvalid - H * W) / W] = int'(vcount);
                last = cyc;
                nvalid++;
            end else begin
                if (pixel != 0) errs_gap++;
                if (nvalid > 0) begin
                    gap++;
                    if (hcount != 5'(W - 1)) errs_gap++;
                end
            end
            if (cyc == 937 && restart_at_done) start = 1'b1;
            if (cyc == 938) begin
                check_eq("busy_low_938", busy, 0);
                if (restart_at_done) break;
            end
        end

        check_eq("first_valid_cycle", first, 3);
        check_eq("last_valid_cycle", last, 936);
        check_eq("valid_count", nvalid, (H + TR) * W);
        check_eq("pixel_errors", errs_pix, 0);
        check_eq("blank_errors", errs_gap, 0);
        check_eq("done_cycle", done_cyc, 937);
        check_eq("done_count", ndone, 1);
        check_eq("mem_reads", nrd, H * W);
        if (mode == 0) check_eq("pix_h5_v10", pix_5_10, 245);
        else           check_eq("pix_h5_v10_sign", pix_5_10, 1048576 - 2097152);
        for (int k = 0; k < TR; k++) check_eq($sformatf("tail_v%0d", k), tail_v[k], k);
    endtask

    initial begin
        rst_n = 1'b0;
        start = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_eq("rst_busy", busy, 0);
        check_eq("rst_done", done, 0);
        check_eq("rst_rd_en", rd_en, 0);
        check_eq("rst_addr", addr, 0);
        check_eq("rst_valid", valid, 0);
        check_eq("rst_pixel", pixel, 0);
        check_eq("rst_hcount", hcount, 0);
        check_eq("rst_vcount", vcount, 0);
        start = 1'b0;
        rst_n = 1'b1;
        @(negedge clk);
        check_eq("idle_after_rst", busy, 0);

        fill_mem(0);
        run_frame(0, 1'b1);
        fill_mem(1);
        run_frame(1, 1'b0);

        fill_mem(0);
        start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        repeat (266) begin
            @(posedge clk);
            @(negedge clk);
        end
        check_eq("pre_rst_valid", valid, 1);
        check_eq("pre_rst_vcount", vcount, 10);
        #2 rst_n = 1'b0;
        #1;
        check_eq("async_rst_outputs", {busy, done, rd_en, addr, valid, pixel, hcount, vcount}, 0);
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        begin
            int nd = 0;
            repeat (10) begin
                @(posedge clk);
                @(negedge clk);
                nd = nd + int'(done);
            end
            check_eq("no_done_after_abort", nd, 0);
        end
        check_eq("idle_after_abort", busy, 0);
        run_frame(0, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
